// File: rtl/logic_gate_sweep_tester.sv
// logic_gate_sweep_tester: clocked exhaustive stimulus/checker for an N-input logic gate
// Ports: clk, reset_L (async active-low), start (pulse, accepted in IDLE/DONE),
//   dut_in (vector to gate), dut_out (gate response), busy, done, pass (valid with done),
//   error_count (saturating mismatch count), first_fail_vec (first mismatching vector, else 0).
// Macro GATE_TESTER_STOP_ON_FAIL_EN: when defined, the first mismatch ends the sweep.
module logic_gate_sweep_tester #(
  parameter int N_INPUTS      = 2,
  parameter int GATE_MODE     = 0,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                start,
  output logic [N_INPUTS-1:0] dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [N_INPUTS:0]   error_count,
  output logic [N_INPUTS-1:0] first_fail_vec
);
  localparam logic [N_INPUTS-1:0] VEC_MAX     = '1;
  localparam logic [N_INPUTS:0]   ERR_MAX     = {1'b1, {N_INPUTS{1'b0}}};
  localparam logic [3:0]          SETTLE_LAST = 4'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;
  state_t              state_q, state_d;
  logic [N_INPUTS-1:0] vec_q, vec_d, din_q, din_d, ffv_q, ffv_d;
  logic [N_INPUTS:0]   err_q, err_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                expected, mismatch;
  always_comb
    expected = GATE_MODE == 1 ? |vec_q  :
               GATE_MODE == 2 ? ^vec_q  :
               GATE_MODE == 3 ? ~&vec_q :
               GATE_MODE == 4 ? ~|vec_q :
               GATE_MODE == 5 ? ~^vec_q : &vec_q;
  // 4-state compare so an X/Z response from the gate is a failure
  always_comb mismatch = (dut_out !== expected);
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    din_d   = din_q;
    ffv_d   = ffv_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = DRIVE;
        vec_d   = '0;
        ffv_d   = '0;
        err_d   = '0;
      end
      DRIVE: begin
        din_d   = vec_q;
        cnt_d   = SETTLE_LAST;
        state_d = SETTLE_CYCLES == 0 ? CHECK : SETTLE;
      end
      SETTLE: begin
        state_d = cnt_q == 4'd0 ? CHECK : SETTLE;
        cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q == ERR_MAX ? err_q : err_q + 1'b1;
          ffv_d = err_q == '0 ? vec_q : ffv_q;
        end
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
        state_d = (mismatch || vec_q == VEC_MAX) ? DONE : DRIVE;
        vec_d   = (mismatch || vec_q == VEC_MAX) ? vec_q : vec_q + 1'b1;
`else
        state_d = vec_q == VEC_MAX ? DONE : DRIVE;
        vec_d   = vec_q == VEC_MAX ? vec_q : vec_q + 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      state_q <= IDLE;
      vec_q   <= '0;
      din_q   <= '0;
      ffv_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      din_q   <= din_d;
      ffv_q   <= ffv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  assign dut_in         = din_q;
  assign busy           = state_q == DRIVE || state_q == SETTLE || state_q == CHECK;
  assign done           = state_q == DONE;
  assign pass           = state_q == DONE && err_q == '0;
  assign error_count    = err_q;
  assign first_fail_vec = ffv_q;
endmodule
